pc_update_ras: RTL and testbench

PC_UPDATE_RAS -- requirements
Module: pc_update_ras

---
 rtl/pc_update_ras.sv | 157 +++++++++++++++
 tb/tb_pc_update_ras.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_update_ras.sv
// Y86-64 program-counter update stage with a small return-address stack.
// On each committed instruction (en=1 while running) the next PC is chosen
// from valC / valM / valP by instruction class. Calls push their fall-through
// address onto a circular return-address stack, and returns pop it and flag a
// one-cycle mispredict when the predicted return address differs from valM.
// halt and invalid opcodes freeze the stage in a sticky HALT or ERR state
// that only rst_n clears.
module pc_update_ras #(
    parameter int                  ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter int                  RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [3:0]                     icode,
    input  logic                           cnd,
    input  logic [ADDR_W-1:0]              valC,
    input  logic [ADDR_W-1:0]              valM,
    input  logic [ADDR_W-1:0]              valP,
    output logic [ADDR_W-1:0]              newPC,
    output logic [1:0]                     state,
    output logic                           ras_mispredict,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic [31:0]                    retired
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Run-state encoding as reported on the state output.
    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_HALT = 2'b01;
    localparam logic [1:0] ST_ERR  = 2'b10;

    // Instruction codes that steer the PC or the stack.
    localparam logic [3:0] IC_HALT = 4'h0;
    localparam logic [3:0] IC_JXX  = 4'h7;
    localparam logic [3:0] IC_CALL = 4'h8;
    localparam logic [3:0] IC_RET  = 4'h9;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Architectural state.
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [1:0]        state_q,   state_d;
    logic              mis_q,     mis_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [PTR_W-1:0]  top_q,     top_d;
    logic [31:0]       retired_q, retired_d;

    // Stack storage; top_q indexes the next slot to write, so the most
    // recent entry lives at top_q-1 and wrapping overwrites the oldest.
    logic [ADDR_W-1:0] stack_q [RAS_DEPTH];

    logic              push_s;
    logic              commit_s;
    logic [PTR_W-1:0]  top_prev_s;
    logic [ADDR_W-1:0] popped_s;

    assign commit_s   = en && (state_q == ST_RUN);
    assign top_prev_s = top_q - PTR_ONE;
    assign popped_s   = stack_q[top_prev_s];

    // Next-state selection for PC, run state, stack pointer/count and counter.
    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        mis_d     = 1'b0;
        cnt_d     = cnt_q;
        top_d     = top_q;
        retired_d = retired_q;
        push_s    = 1'b0;
        if (commit_s) begin
            case (icode)
                IC_HALT: begin
                    state_d = ST_HALT;
                end
                IC_JXX: begin
                    if (cnd) begin
                        pc_d = valC;
                    end else begin
                        pc_d = valP;
                    end
                    retired_d = retired_q + 32'd1;
                end
                IC_CALL: begin
                    pc_d      = valC;
                    push_s    = 1'b1;
                    top_d     = top_q + PTR_ONE;
                    if (cnt_q == CNT_FULL) begin
                        cnt_d = cnt_q;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    retired_d = retired_q + 32'd1;
                end
                IC_RET: begin
                    pc_d = valM;
                    if (cnt_q != CNT_ZERO) begin
                        top_d = top_prev_s;
                        cnt_d = cnt_q - CNT_ONE;
                        mis_d = (popped_s != valM);
                    end else begin
                        mis_d = 1'b0;
                    end
                    retired_d = retired_q + 32'd1;
                end
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: begin
                    pc_d      = valP;
                    retired_d = retired_q + 32'd1;
                end
                default: begin
                    state_d = ST_ERR;
                end
            endcase
        end else begin
            mis_d = 1'b0;
        end
    end

    // Control registers with immediate reset to the power-on values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            state_q   <= ST_RUN;
            mis_q     <= 1'b0;
            cnt_q     <= CNT_ZERO;
            top_q     <= {PTR_W{1'b0}};
            retired_q <= 32'd0;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            mis_q     <= mis_d;
            cnt_q     <= cnt_d;
            top_q     <= top_d;
            retired_q <= retired_d;
        end
    end

    // Stack entry write on call; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_q[top_q] <= valP;
        end
    end

    assign newPC          = pc_q;
    assign state          = state_q;
    assign ras_mispredict = mis_q;
    assign ras_count      = cnt_q;
    assign retired        = retired_q;

endmodule

// File: tb/tb_pc_update_ras.sv
// Bench for pc_update_ras: directed scenarios followed by a randomized run,
// both checked against a behavioural model built on a bounded queue.
module tb_pc_update_ras;

    localparam int ADDR_W    = 64;
    localparam int RAS_DEPTH = 4;
    localparam int CNT_W     = $clog2(RAS_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [3:0]        icode = 4'h1;
    logic              cnd = 1'b0;
    logic [ADDR_W-1:0] valC = '0;
    logic [ADDR_W-1:0] valM = '0;
    logic [ADDR_W-1:0] valP = '0;
    logic [ADDR_W-1:0] newPC;
    logic [1:0]        state;
    logic              ras_mispredict;
    logic [CNT_W-1:0]  ras_count;
    logic [31:0]       retired;

    pc_update_ras #(.ADDR_W(ADDR_W), .RESET_PC(64'h0), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .icode(icode), .cnd(cnd),
        .valC(valC), .valM(valM), .valP(valP), .newPC(newPC), .state(state),
        .ras_mispredict(ras_mispredict), .ras_count(ras_count), .retired(retired)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model.
    logic [63:0] m_pc;
    logic [1:0]  m_st;
    logic        m_mis;
    logic [31:0] m_ret;
    logic [63:0] m_stack [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".newPC"}, newPC, m_pc);
        chk({tag, ".state"}, {62'd0, state}, {62'd0, m_st});
        chk({tag, ".ras_count"}, 64'(ras_count), 64'(m_stack.size()));
        chk({tag, ".mispredict"}, {63'd0, ras_mispredict}, {63'd0, m_mis});
        chk({tag, ".retired"}, {32'd0, retired}, {32'd0, m_ret});
    endtask

    task automatic model_reset();
        m_pc  = 64'h0;
        m_st  = 2'b00;
        m_mis = 1'b0;
        m_ret = 32'd0;
        m_stack.delete();
    endtask

    task automatic model_step(input logic e, input logic [3:0] ic, input logic c,
                              input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp);
        logic [63:0] ent;
        m_mis = 1'b0;
        if (e && m_st == 2'b00) begin
            if (ic == 4'h0) begin
                m_st = 2'b01;
            end else if (ic >= 4'hC) begin
                m_st = 2'b10;
            end else begin
                m_ret = m_ret + 32'd1;
                if (ic == 4'h8) begin
                    m_pc = vc;
                    m_stack.push_back(vp);
                    if (m_stack.size() > RAS_DEPTH) void'(m_stack.pop_front());
                end else if (ic == 4'h9) begin
                    m_pc = vm;
                    if (m_stack.size() > 0) begin
                        ent = m_stack.pop_back();
                        m_mis = (ent != vm);
                    end
                end else if (ic == 4'h7) begin
                    m_pc = c ? vc : vp;
                end else begin
                    m_pc = vp;
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, check just after the rising edge.
    task automatic step(input string tag, input logic e, input logic [3:0] ic, input logic c,
                        input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp);
        @(negedge clk);
        en = e; icode = ic; cnd = c; valC = vc; valM = vm; valP = vp;
        model_step(e, ic, c, vc, vm, vp);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Reset applied away from the clock edge; outputs must respond at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [63:0] vc, vm, vp;
        logic [3:0]  ic;
        logic        e;
        int          r;

        model_reset();
        #1;
        check_all("por");
        do_reset("reset");

        // Call then matching return, then a mismatching return.
        step("call1", 1'b1, 4'h8, 1'b0, 64'h0123456789ABCDEF, 64'h0, 64'h100);
        step("ret1", 1'b1, 4'h9, 1'b0, 64'h0, 64'h100, 64'h0);
        step("call2", 1'b1, 4'h8, 1'b0, 64'h0123456789ABCDEF, 64'h0, 64'h100);
        step("ret_bad", 1'b1, 4'h9, 1'b0, 64'h0, 64'h200, 64'h0);
        step("mis_clear", 1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 64'h0);

        // Conditional jump both ways with idle cycles between.
        step("jxx_taken", 1'b1, 4'h7, 1'b1, 64'h1111111111111111, 64'h0, 64'h2222222222222222);
        step("idle1", 1'b0, 4'h7, 1'b0, 64'h0, 64'h0, 64'h3333);
        step("idle2", 1'b0, 4'h8, 1'b1, 64'h5555, 64'h0, 64'h3333);
        step("jxx_not", 1'b1, 4'h7, 1'b0, 64'h1111111111111111, 64'h0, 64'h2222222222222222);

        // Six calls overflow the four-entry stack; five returns drain it.
        for (int i = 1; i <= 6; i++)
            step("ovf_call", 1'b1, 4'h8, 1'b0, 64'h4000 + 64'(i), 64'h0, 64'(i));
        for (int i = 6; i >= 2; i--)
            step("ovf_ret", 1'b1, 4'h9, 1'b0, 64'h0, 64'(i), 64'h0);
        step("empty_ret", 1'b1, 4'h9, 1'b0, 64'h0, 64'h77, 64'h0);

        // Halt is sticky and ignores later commits.
        step("halt", 1'b1, 4'h0, 1'b0, 64'h0, 64'h0, 64'h999);
        step("halt_call", 1'b1, 4'h8, 1'b0, 64'hABC, 64'h0, 64'hDEF);
        step("halt_ret", 1'b1, 4'h9, 1'b0, 64'h0, 64'hABC, 64'h0);
        do_reset("reset_halt");
        step("err", 1'b1, 4'hE, 1'b0, 64'h0, 64'h0, 64'h10);
        step("err_nop", 1'b1, 4'h1, 1'b0, 64'h0, 64'h0, 64'h20);

        // Reset out of ERR with a non-zero retired count.
        do_reset("reset_err0");
        for (int i = 0; i < 5; i++)
            step("nop5", 1'b1, 4'h1, 1'b0, 64'h0, 64'h0, 64'h10 * 64'(i + 1));
        step("call_err", 1'b1, 4'h8, 1'b0, 64'h900, 64'h0, 64'h50);
        step("err5", 1'b1, 4'hD, 1'b0, 64'h0, 64'h0, 64'h0);
        do_reset("reset_err5");

        // Retired counter wrap.
        @(negedge clk);
        en = 1'b0;
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFFFFFF;
        chk("ret_preset", {32'd0, retired}, 64'h00000000FFFFFFFF);
        step("ret_wrap", 1'b1, 4'h1, 1'b0, 64'h0, 64'h0, 64'h88);

        // Randomized commits against the model.
        for (int n = 0; n < 400; n++) begin
            if (m_st != 2'b00 && $urandom_range(3, 0) == 0) do_reset("rand_reset");
            r  = $urandom_range(99, 0);
            if (r < 3)      ic = 4'h0;
            else if (r < 6) ic = 4'hC + 4'($urandom_range(3, 0));
            else            ic = 4'h1 + 4'($urandom_range(10, 0));
            e  = ($urandom_range(3, 0) != 0);
            vc = {$urandom, $urandom};
            vp = {$urandom, $urandom};
            if (m_stack.size() > 0 && $urandom_range(1, 0) == 0) vm = m_stack[$];
            else vm = {$urandom, $urandom};
            step("rand", e, ic, 1'($urandom_range(1, 0)), vc, vm, vp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
